accel_bcd_seq: RTL

- Multi-channel, sequential two's-complement to signed-BCD converter for accelerometer axis samples.
- Captures all axes with one valid/ready handshake and converts one channel at a time with a one-bit-per-clock shift-add-3 engine.
- Presents the mG-scaled decimal digits, a sign flag and an overflow flag per channel to the display/UART formatting logic.
- Replaces the purely combinational, single-axis, fixed-width converter.

---
 rtl/accel_bcd_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/accel_bcd_seq.sv
// Sequential multi-channel two's-complement to signed-BCD converter (shift-add-3, 1 bit/clk).
// Optional leading-zero blanking (4'hF) enabled by defining ACCEL_BCD_BLANK_LEAD_EN.
module accel_bcd_seq #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned DIGITS      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_CH*16-1:0]       accel_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_CH*DIGITS*4-1:0] bcd_digits,
    output logic [NUM_CH-1:0]          negative,
    output logic [NUM_CH-1:0]          overflow,
    output logic                       busy
);
    localparam int unsigned W     = DATA_W + SCALE_SHIFT;
    localparam int unsigned DW    = 4 * DIGITS;
    localparam int unsigned BW    = 4 * (DIGITS + 1);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(W);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e                  state_q;
    logic [CH_W-1:0]         ch_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [15:0]             data_q [NUM_CH];
    logic [W-1:0]            sh_q;
    logic [BW-1:0]           bcd_q;
    logic                    lost_q;
    logic [NUM_CH*DW-1:0]    res_dig_q;
    logic [NUM_CH-1:0]       res_neg_q;
    logic [NUM_CH-1:0]       res_ovf_q;

    logic [15:0]             cur;
    logic [15:0]             raw;
    logic [DATA_W-1:0]       sample;
    logic [DATA_W-1:0]       mag;
    logic [W-1:0]            scaled;
    logic [BW-1:0]           adj;
    logic [BW-1:0]           bcd_nx;
    logic                    lost_nx;
    logic                    ovf_nx;
    logic [DW-1:0]           dig_nx;
    logic [NUM_CH*DW-1:0]    res_dig_nx;
    logic [NUM_CH-1:0]       res_neg_nx;
    logic [NUM_CH-1:0]       res_ovf_nx;
`ifdef ACCEL_BCD_BLANK_LEAD_EN
    logic                    lead;
`endif

    if (DATA_W < 16) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^raw[15:DATA_W];
    end

    always_comb begin
        cur    = data_q[ch_q];
        raw    = {cur[7:0], cur[15:8]};
        sample = raw[DATA_W-1:0];
        // Unsigned magnitude: the most negative value maps to 2^(DATA_W-1) without wrapping.
        mag    = sample[DATA_W-1] ? (~sample + DATA_W'(1)) : sample;
        scaled = W'(mag) << SCALE_SHIFT;

        adj = bcd_q;
        for (int i = 0; i <= int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_nx  = {adj[BW-2:0], sh_q[W-1]};
        // Sticky: any carry out of the guard nibble also means the value did not fit.
        lost_nx = lost_q | adj[BW-1];
        ovf_nx  = lost_nx | (bcd_nx[BW-1 -: 4] != 4'h0);
        dig_nx  = ovf_nx ? {DIGITS{4'h9}} : bcd_nx[DW-1:0];
`ifdef ACCEL_BCD_BLANK_LEAD_EN
        lead = !ovf_nx;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (lead && dig_nx[4*i +: 4] == 4'h0) dig_nx[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        res_dig_nx                          = res_dig_q;
        res_dig_nx[int'(ch_q)*DW +: DW]     = dig_nx;
        res_neg_nx                          = res_neg_q;
        res_neg_nx[ch_q]                    = sample[DATA_W-1];
        res_ovf_nx                          = res_ovf_q;
        res_ovf_nx[ch_q]                    = ovf_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            bcd_digits <= '0;
            negative   <= '0;
            overflow   <= '0;
            ch_q       <= '0;
            cnt_q      <= '0;
            sh_q       <= '0;
            bcd_q      <= '0;
            lost_q     <= 1'b0;
            res_dig_q  <= '0;
            res_neg_q  <= '0;
            res_ovf_q  <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) data_q[c] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        for (int c = 0; c < int'(NUM_CH); c++) data_q[c] <= accel_data[16*c +: 16];
                        ch_q     <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    sh_q    <= scaled;
                    bcd_q   <= '0;
                    lost_q  <= 1'b0;
                    cnt_q   <= CNT_W'(W - 1);
                    state_q <= StShift;
                end
                StShift: begin
                    bcd_q  <= bcd_nx;
                    lost_q <= lost_nx;
                    sh_q   <= sh_q << 1;
                    if (cnt_q == '0) begin
                        res_dig_q <= res_dig_nx;
                        res_neg_q <= res_neg_nx;
                        res_ovf_q <= res_ovf_nx;
                        if (ch_q == CH_W'(NUM_CH - 1)) begin
                            bcd_digits <= res_dig_nx;
                            negative   <= res_neg_nx;
                            overflow   <= res_ovf_nx;
                            out_valid  <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            ch_q    <= ch_q + CH_W'(1);
                            state_q <= StLoad;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
